// File: rtl/bnn_pkg.sv
// Shared dataset constants, derived widths and the sequencer state type
// for the sequential BNN classifier front end.
package bnn_pkg;

   localparam int FEAT_CNT   = 11;
   localparam int FEAT_BITS  = 4;
   localparam int HIDDEN_CNT = 40;
   localparam int CLASS_CNT  = 6;

   // Classifier cycles from reset deassert to a valid prediction
   localparam int LATENCY    = FEAT_CNT + HIDDEN_CNT;

   localparam int CLASS_BITS = $clog2(CLASS_CNT);
   localparam int FRAME_BITS = FEAT_BITS * FEAT_CNT;
   localparam int CNT_BITS   = $clog2(LATENCY + 1);
   localparam int WCNT_BITS  = $clog2(FEAT_CNT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/bnn_frame_packer.sv
// Packs a valid/ready stream of feature words into a shadow frame register.
// The first word of a frame lands in the MSB slice. A frame ends on the
// FEAT_CNT-th word or on an early in_last; any in_last misplacement pulses
// frame_err. The shadow holds one complete frame until the sequencer takes it.
//
// Handshake: a word moves on every rising edge where in_valid && in_ready;
// in_ready depends only on registered state, so it never combinationally
// follows in_valid.
module bnn_frame_packer
   import bnn_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FEAT_BITS-1:0]  in_data,
   input  logic                  in_last,
   input  logic                  take,
   output logic [FRAME_BITS-1:0] shadow,
   output logic                  shadow_full,
   output logic                  frame_err
);

   logic [WCNT_BITS-1:0]  wcnt;
   logic                  rdy_en;
   logic                  xfer;
   logic                  is_final;
   logic                  done;
   logic [FRAME_BITS-1:0] shadow_next;

   assign in_ready = rdy_en && !shadow_full;
   assign xfer     = in_valid && in_ready;
   assign is_final = (wcnt == WCNT_BITS'(FEAT_CNT - 1));
   assign done     = xfer && (is_final || in_last);

   // Next shadow value: the first word of a frame zeroes the rest so a
   // truncated frame leaves its unfilled slices at 0
   always_comb begin
      shadow_next = shadow;
      if (xfer) begin
         if (wcnt == '0) shadow_next = '0;
         for (int i = 0; i < FEAT_CNT; i++) begin
            if (wcnt == WCNT_BITS'(i))
               shadow_next[FEAT_BITS*(FEAT_CNT-1-i) +: FEAT_BITS] = in_data;
         end
      end
   end

   // Shadow data, word count, full flag, framing error and ready enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow      <= '0;
         wcnt        <= '0;
         shadow_full <= 1'b0;
         frame_err   <= 1'b0;
         rdy_en      <= 1'b0;
      end else begin
         rdy_en    <= 1'b1;
         shadow    <= shadow_next;
         frame_err <= xfer && (in_last != is_final);
         if (done)      wcnt <= '0;
         else if (xfer) wcnt <= wcnt + WCNT_BITS'(1);
         if (take)      shadow_full <= 1'b0;
         if (done)      shadow_full <= 1'b1;
      end
   end

endmodule

// File: rtl/bnn_frame_sequencer.sv
// Feeds the sequential BNN classifier: takes a packed frame from the shadow
// buffer, pulses the classifier reset, waits LATENCY cycles, captures the
// prediction and offers it on a valid/ready output. The next frame may load
// into the shadow buffer while the current one is classified.
//
// Handshake: the result moves on every rising edge where out_valid &&
// out_ready; out_valid is a pure function of the state register.
module bnn_frame_sequencer
   import bnn_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FEAT_BITS-1:0]  in_data,
   input  logic                  in_last,
   output logic [FRAME_BITS-1:0] features,
   output logic                  clf_rst,
   input  logic [CLASS_BITS-1:0] prediction,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CLASS_BITS-1:0] out_class,
   output logic                  out_err,
   output logic                  frame_err,
   output logic                  busy,
   output state_t                dbg_state
);

   state_t                state;
   state_t                state_next;
   logic [CNT_BITS-1:0]   cnt;
   logic [FRAME_BITS-1:0] shadow;
   logic                  shadow_full;
   logic                  load;
   logic                  cap;

   bnn_frame_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .take        (load),
      .shadow      (shadow),
      .shadow_full (shadow_full),
      .frame_err   (frame_err)
   );

   // A new frame enters the classifier from IDLE, or straight out of HOLD
   // on the result handshake when another frame is already waiting
   assign load = shadow_full &&
                 ((state == IDLE) || ((state == HOLD) && out_ready));
   assign cap  = (state == RUN) && (cnt == CNT_BITS'(LATENCY - 1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (shadow_full) state_next = START;
         START:   state_next = RUN;
         RUN:     if (cap) state_next = HOLD;
         HOLD:    if (out_ready) state_next = shadow_full ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      clf_rst   = (state == IDLE) || (state == START);
      out_valid = (state == HOLD);
      busy      = (state != IDLE) || shadow_full;
      dbg_state = state;
   end

   // Active frame, latency counter and captured result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         features  <= '0;
         cnt       <= '0;
         out_class <= '0;
         out_err   <= 1'b0;
      end else begin
         if (load) features <= shadow;
         if (state == START)    cnt <= '0;
         else if (state == RUN) cnt <= cnt + CNT_BITS'(1);
         if (cap) begin
            out_class <= prediction;
            out_err   <= (prediction > CLASS_BITS'(CLASS_CNT - 1));
         end
      end
   end

endmodule

// File: tb/tb_bnn_frame_sequencer.sv
// Directed bench for bnn_frame_sequencer with a trivial classifier model
// whose prediction is a bench-controlled constant.
module tb_bnn_frame_sequencer;
   import bnn_pkg::*;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [FEAT_BITS-1:0]  in_data;
   logic                  in_last;
   logic [FRAME_BITS-1:0] features;
   logic                  clf_rst;
   logic [CLASS_BITS-1:0] prediction;
   logic                  out_valid;
   logic                  out_ready;
   logic [CLASS_BITS-1:0] out_class;
   logic                  out_err;
   logic                  frame_err;
   logic                  busy;
   state_t                dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int start_cnt = 0;
   int low_cnt = 0;
   int hs_cnt = 0;
   int ov_cnt = 0;
   int t_last = 0;

   bnn_frame_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .features   (features),
      .clf_rst    (clf_rst),
      .prediction (prediction),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_class  (out_class),
      .out_err    (out_err),
      .frame_err  (frame_err),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter and event monitors (pre-edge values)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dbg_state == START)     start_cnt <= start_cnt + 1;
      if (!clf_rst)               low_cnt   <= low_cnt + 1;
      if (out_valid && out_ready) hs_cnt    <= hs_cnt + 1;
      if (out_valid)              ov_cnt    <= ov_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [FEAT_BITS-1:0] d, input logic l);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) chk("in_ready_timeout", in_ready, 1);
      tick();
      t_last   = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // last_pos < 0 means in_last never asserted
   task automatic send_frame(input logic [FRAME_BITS-1:0] fr, input int n_words, input int last_pos);
      for (int k = 0; k < n_words; k++)
         send_word(fr[FRAME_BITS-1-FEAT_BITS*k -: FEAT_BITS], (k == last_pos));
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) chk(tag, out_valid, 1);
   endtask

   int s0, l0, h0, o0, glitch;

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0; prediction = '0;

      // reset values
      #22;
      chk("rst_features", features, 0);
      chk("rst_clf_rst", clf_rst, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      #1 rst = 1'b1;
      tick();
      chk("rel_in_ready", in_ready, 1);

      // nominal frame
      out_ready = 1'b1; prediction = 3'd3;
      s0 = start_cnt; l0 = low_cnt;
      send_frame(44'h123456789AB, 11, 10);
      chk("nom_no_frame_err", frame_err, 0);
      wait_valid("nom_valid_timeout");
      chk("nom_latency", 64'(cyc - t_last), 53);
      chk("nom_features", features, 44'h123456789AB);
      chk("nom_class", out_class, 3);
      chk("nom_err", out_err, 0);
      chk("nom_clf_rst_low", clf_rst, 0);
      tick();
      chk("nom_valid_drop", out_valid, 0);
      chk("nom_idle", dbg_state, IDLE);
      chk("nom_start_pulses", 64'(start_cnt - s0), 1);
      chk("nom_low_cycles", 64'(low_cnt - l0), 52);

      // back-to-back frames
      prediction = 3'd1;
      send_frame(44'hFEDCBA98765, 11, 10);
      send_frame(44'hA5A5A5A5A5A, 11, 10);
      chk("b2b_in_ready_low", in_ready, 0);
      chk("b2b_busy", busy, 1);
      chk("b2b_features_a", features, 44'hFEDCBA98765);
      wait_valid("b2b_a_timeout");
      chk("b2b_class_a", out_class, 1);
      prediction = 3'd5;
      tick();
      chk("b2b_direct_start", dbg_state, START);
      chk("b2b_features_b", features, 44'hA5A5A5A5A5A);
      chk("b2b_in_ready_back", in_ready, 1);
      wait_valid("b2b_b_timeout");
      chk("b2b_class_b", out_class, 5);
      chk("b2b_err_b", out_err, 0);
      tick();

      // output stall with a second frame buffered
      out_ready = 1'b0; prediction = 3'd2;
      send_frame(44'h0F1E2D3C4B5, 11, 10);
      send_frame(44'h13579BDF024, 11, 10);
      wait_valid("stall_timeout");
      glitch = 0;
      repeat (100) begin
         tick();
         if (!out_valid || out_class != 3'd2 || features != 44'h0F1E2D3C4B5 || in_ready)
            glitch++;
      end
      chk("stall_glitches", glitch, 0);
      chk("stall_class", out_class, 2);
      chk("stall_in_ready", in_ready, 0);
      h0 = hs_cnt;
      out_ready = 1'b1; prediction = 3'd4;
      tick();
      chk("stall_one_xfer", 64'(hs_cnt - h0), 1);
      chk("stall_valid_drop", out_valid, 0);
      chk("stall_next_start", dbg_state, START);
      chk("stall_features_d", features, 44'h13579BDF024);
      wait_valid("stall_d_timeout");
      chk("stall_class_d", out_class, 4);
      tick();

      // early in_last on word 7
      prediction = 3'd0;
      send_frame(44'h98765430000, 7, 6);
      chk("early_frame_err", frame_err, 1);
      tick();
      chk("early_frame_err_clr", frame_err, 0);
      wait_valid("early_timeout");
      chk("early_features", features, 44'h98765430000);
      chk("early_low16", features[15:0], 0);
      tick();

      // in_last missing on word 11; class 6 is just past the legal range
      prediction = 3'd6;
      send_frame(44'hCCCCCCCCCCC, 11, -1);
      chk("miss_frame_err", frame_err, 1);
      wait_valid("miss_timeout");
      chk("miss_features", features, 44'hCCCCCCCCCCC);
      chk("miss_class", out_class, 6);
      chk("miss_err", out_err, 1);
      tick();

      // illegal class 7
      prediction = 3'd7;
      send_frame(44'h2468ACE1357, 11, 10);
      wait_valid("ill_timeout");
      chk("ill_class", out_class, 7);
      chk("ill_err", out_err, 1);
      tick();

      // async reset during RUN at cnt=20
      prediction = 3'd3;
      send_frame(44'h11111111111, 11, 10);
      repeat (22) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_features", features, 0);
      chk("arst_clf_rst", clf_rst, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_state", dbg_state, IDLE);
      chk("arst_busy", busy, 0);
      tick();
      rst = 1'b1;
      o0 = ov_cnt;
      repeat (80) tick();
      chk("arst_no_result", 64'(ov_cnt - o0), 0);
      chk("arst_idle_clf_rst", clf_rst, 1);
      chk("arst_in_ready_back", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
